// File: rtl/cp_in_buf_ctrl.sv
// cp_in_buf_ctrl: AES input block buffer; collects 32-bit lane writes per 128-bit entry
// and streams complete blocks in index order over a valid/ready handshake.
module cp_in_buf_ctrl #(
  parameter int ADDR_W = 7
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iWrEn_CpInBuf,
  input  logic [3:0]        iWdSel_CpInBuf,
  input  logic [ADDR_W-1:0] iWrAddr_CpInBuf,
  input  logic [127:0]      iWrDt_CpInBuf,
  input  logic              iStart,
  input  logic [ADDR_W:0]   iBlkNum,
  output logic              oBlkVld,
  input  logic              iBlkRdy,
  output logic [127:0]      oBlkDt,
  output logic [ADDR_W-1:0] oBlkIdx,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, PRESENT, DONE} state_t;
  state_t                r_state, w_nxt;
  logic [127:0]          r_mem [DEPTH];
  logic [DEPTH-1:0][3:0] r_mask;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_cnt;
  logic [127:0]          r_blk_dt;
  logic [ADDR_W-1:0]     r_blk_idx;
  logic                  r_err;
  logic                  w_full, w_hs, w_last, w_hit;
  assign w_full = r_mask[r_rd_ptr] == 4'hF;
  assign w_hs   = r_state == PRESENT && iBlkRdy;
  assign w_last = {1'b0, r_rd_ptr} == r_cnt - 1'b1;
  // Any lane write landing on the block currently on the output is an in-flight overwrite.
  assign w_hit  = r_state == PRESENT && iWrEn_CpInBuf && |iWdSel_CpInBuf && iWrAddr_CpInBuf == r_rd_ptr;
  always_ff @(posedge iClk)
    if (!iRsn) r_state <= IDLE;
    else       r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (iStart) w_nxt = iBlkNum == '0 ? DONE : WAIT;
      WAIT:    if (w_full) w_nxt = PRESENT;
      PRESENT: if (iBlkRdy) w_nxt = w_last ? DONE : WAIT;
      default: w_nxt = IDLE;
    endcase
  end
  always_comb begin
    oBlkVld = r_state == PRESENT;
    oBusy   = r_state != IDLE;
    oDone   = r_state == DONE;
  end
  assign oBlkDt  = r_blk_dt;
  assign oBlkIdx = r_blk_idx;
  assign oErr    = r_err;
  always_ff @(posedge iClk)
    for (int k = 0; k < 4; k++)
      if (iWrEn_CpInBuf && iWdSel_CpInBuf[k]) r_mem[iWrAddr_CpInBuf][32*k +: 32] <= iWrDt_CpInBuf[32*k +: 32];
  // Handshake clear is applied last so it wins over a same-cycle lane write.
  always_ff @(posedge iClk)
    if (!iRsn) r_mask <= '0;
    else begin
      for (int k = 0; k < 4; k++)
        if (iWrEn_CpInBuf && iWdSel_CpInBuf[k]) r_mask[iWrAddr_CpInBuf][k] <= 1'b1;
      if (w_hs) r_mask[r_rd_ptr] <= 4'h0;
    end
  always_ff @(posedge iClk)
    if (!iRsn) begin
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_blk_dt  <= '0;
      r_blk_idx <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == IDLE && iStart) begin
        r_cnt    <= iBlkNum > CNT_MAX ? CNT_MAX : iBlkNum;
        r_rd_ptr <= '0;
        r_err    <= 1'b0;
      end
      if (r_state == WAIT && w_full) begin
        r_blk_dt  <= r_mem[r_rd_ptr];
        r_blk_idx <= r_rd_ptr;
      end
      if (w_hs && !w_last) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_hit) r_err <= 1'b1;
    end
endmodule
